// File: rtl/cmp_minmax_tracker.sv
// Windowed min/max tracker: folds WINDOW unsigned samples into max, min and a
// tie count, then holds the result until the consumer acknowledges it.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   EMPTY  | no sample yet in the current window
//   TRACK  | window in progress
//   REPORT | result held, input stalled until result_ack
module cmp_minmax_tracker #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] tie_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  generate
    if ((WINDOW < 1) || (WINDOW > (2 ** CNT_W) - 1)) begin : g_bad_window
      $error("cmp_minmax_tracker: WINDOW must lie in 1 .. 2**CNT_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic [CNT_W-1:0] r_tie;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  // Subtract-based compare: the extra top bit is the borrow, so a<b shows up
  // as borrow and the all-zero / all-one codes never wrap.
  logic [WIDTH:0]   w_diff_max;
  logic [WIDTH:0]   w_diff_min;
  logic             w_gt_max;
  logic             w_eq_max;
  logic             w_lt_min;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_diff_max = {1'b0, in_data} - {1'b0, r_max};
  assign w_diff_min = {1'b0, in_data} - {1'b0, r_min};
  assign w_eq_max   = (w_diff_max == '0);
  assign w_gt_max   = !w_diff_max[WIDTH] && !w_eq_max;
  assign w_lt_min   = w_diff_min[WIDTH] && (w_diff_min != '0);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  assign in_ready     = (r_state != REPORT);
  assign result_valid = r_valid;
  assign max_val      = r_max;
  assign min_val      = r_min;
  assign tie_cnt      = r_tie;
  assign sample_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_max   <= '0;
      r_min   <= '0;
      r_tie   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      // max/min are left as-is; the next first accept overwrites them anyway
      r_state <= EMPTY;
      r_tie   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (in_valid) begin
            r_max <= in_data;
            r_min <= in_data;
            r_tie <= '0;
            r_cnt <= CNT_W'(1);
            if (WINDOW == 1) begin
              r_state <= REPORT;
              r_valid <= 1'b1;
            end else begin
              r_state <= TRACK;
            end
          end
        end
        TRACK: begin
          if (in_valid) begin
            if (w_gt_max) r_max <= in_data;
            if (w_lt_min) r_min <= in_data;
            if (w_eq_max) r_tie <= r_tie + CNT_W'(1);
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_W'(WINDOW)) begin
              r_state <= REPORT;
              r_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (result_ack) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Bench for cmp_minmax_tracker: a window-list model checked every cycle plus
// hand-computed literal expectations for each directed scenario.
module tb_cmp_minmax_tracker;

  localparam int WIDTH  = 4;
  localparam int WINDOW = 4;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             result_valid;
  logic             result_ack;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic [CNT_W-1:0] tie_cnt;
  logic [CNT_W-1:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  cmp_minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .max_val      (max_val),
    .min_val      (min_val),
    .tie_cnt      (tie_cnt),
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted samples of the current window as a list; outputs are
  // recomputed from the whole list after each accept.
  int m_win[$];
  bit m_known   = 0;
  bit m_report  = 0;
  bit m_rv      = 0;
  int m_max     = 0;
  int m_min     = 0;
  int m_tie     = 0;
  int m_cnt     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1; m_report = 0; m_rv = 0;
      m_max = 0; m_min = 0; m_tie = 0; m_cnt = 0;
      m_win.delete();
    end else if (clear) begin
      m_report = 0; m_rv = 0; m_tie = 0; m_cnt = 0;
      m_win.delete();
    end else if (m_report) begin
      if (result_ack) begin
        m_report = 0; m_rv = 0;
        m_win.delete();
      end
    end else if (in_valid) begin
      int run_max;
      m_win.push_back(int'(in_data));
      m_max = m_win[0]; m_min = m_win[0]; m_tie = 0;
      run_max = m_win[0];
      for (int i = 1; i < m_win.size(); i++) begin
        if (m_win[i] == run_max) m_tie++;
        if (m_win[i] > run_max) run_max = m_win[i];
        if (m_win[i] > m_max) m_max = m_win[i];
        if (m_win[i] < m_min) m_min = m_win[i];
      end
      m_cnt = m_win.size();
      if (m_cnt == WINDOW) begin
        m_report = 1; m_rv = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("in_ready",     int'(in_ready),     int'(!m_report));
      check("result_valid", int'(result_valid), int'(m_rv));
      check("max_val",      int'(max_val),      m_max);
      check("min_val",      int'(min_val),      m_min);
      check("tie_cnt",      int'(tie_cnt),      m_tie);
      check("sample_cnt",   int'(sample_cnt),   m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream4(input int a, input int b, input int c, input int d);
    int v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(v[i]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int mx, input int mn,
                               input int tie, input int cnt);
    check({tag, ".valid"}, int'(result_valid), 1);
    check({tag, ".max"},   int'(max_val),      mx);
    check({tag, ".min"},   int'(min_val),      mn);
    check({tag, ".tie"},   int'(tie_cnt),      tie);
    check({tag, ".cnt"},   int'(sample_cnt),   cnt);
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ack.valid_drop", int'(result_valid), 0);
  endtask

  initial begin
    int pat_v[7];
    int pat_d[7];
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 4'd7; result_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("reset.valid", int'(result_valid), 0);
    check("reset.ready", int'(in_ready), 1);
    check("reset.max",   int'(max_val), 0);
    check("reset.cnt",   int'(sample_cnt), 0);

    stream4(3, 1, 2, 4);
    expect_result("basic", 4, 1, 0, 4);
    check("basic.ready", int'(in_ready), 0);
    ack();

    stream4(8, 8, 8, 8);
    expect_result("ties", 8, 8, 3, 4);
    ack();
    stream4(15, 0, 15, 0);
    expect_result("extremes", 15, 0, 1, 4);
    ack();

    // Backpressure: sample 5 waits while the result is held.
    stream4(3, 1, 2, 4);
    in_valid = 1'b1; in_data = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.ready", int'(in_ready), 0);
      expect_result("bp", 4, 1, 0, 4);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("bp.valid_drop", int'(result_valid), 0);
    check("bp.ready_back", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp.first.max", int'(max_val), 5);
    check("bp.first.min", int'(min_val), 5);
    check("bp.first.cnt", int'(sample_cnt), 1);
    stream4(7, 3, 5, 0);
    expect_result("bp.win", 7, 3, 0, 4);
    ack();

    // Gaps: junk data on idle cycles must not be taken.
    pat_v = '{1, 0, 0, 1, 1, 0, 1};
    pat_d = '{6, 15, 0, 2, 9, 15, 7};
    for (int i = 0; i < 7; i++) begin
      in_valid = pat_v[i][0];
      in_data  = WIDTH'(pat_d[i]);
      tick();
      if (i == 5) check("gaps.no_early", int'(result_valid), 0);
    end
    in_valid = 1'b0;
    expect_result("gaps", 9, 2, 0, 4);
    ack();

    // Clear mid-window, with a sample offered in the clear cycle.
    in_valid = 1'b1; in_data = 4'd10; tick();
    in_data = 4'd12; tick();
    clear = 1'b1; in_data = 4'd0; tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clear.cnt", int'(sample_cnt), 0);
    check("clear.tie", int'(tie_cnt), 0);
    stream4(1, 2, 3, 4);
    expect_result("clear", 4, 1, 0, 4);

    // clear together with ack in REPORT behaves as clear.
    clear = 1'b1; result_ack = 1'b1; tick();
    clear = 1'b0; result_ack = 1'b0;
    check("clear_ack.valid", int'(result_valid), 0);
    check("clear_ack.cnt",   int'(sample_cnt), 0);
    check("clear_ack.ready", int'(in_ready), 1);

    // Reset mid-window with a sample present.
    in_valid = 1'b1; in_data = 4'd5; tick();
    in_data = 4'd6; tick();
    rst = 1'b1; in_data = 4'd9; tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_mid.valid", int'(result_valid), 0);
    check("rst_mid.max",   int'(max_val), 0);
    check("rst_mid.min",   int'(min_val), 0);
    check("rst_mid.cnt",   int'(sample_cnt), 0);
    check("rst_mid.tie",   int'(tie_cnt), 0);
    tick();
    check("rst_mid.idle_cnt", int'(sample_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
